ase_fifo_drain: RTL
===================

// Module: ase_fifo_drain
//
// PURPOSE
//  Read-side engine for an ASE sync FIFO with a registered empty flag and a
//  1-cycle read latency.
//  - Issues rd_en pulses toward the FIFO.
//  - Absorbs the read latency in a small skid buffer.
//  - Presents the data downstream as a valid/ready stream.
//  - Supports a flush that empties the FIFO and discards its contents.
//  - Sits between a request/response FIFO and the ASE consumer logic.
//
// PARAMETERS
//  DATA_WIDTH  64  payload width; must equal the FIFO data width
//  BUF_DEPTH   2   skid buffer entries; >=2 needed for 1 beat/clk
//  CNT_WIDTH   32  width of beat_count and null_rd_count
//
// PORTS
//  clk            in   1           clock
//  rst            in   1           synchronous reset, active-high
//  enable         in   1           1 = fetch from FIFO; 0 = stop issuing reads
//  flush_req      in   1           pulse: discard buffer and drain FIFO
//  fifo_rd_en     out  1           read strobe to FIFO
//  fifo_data      in   DATA_WIDTH  FIFO read data, valid with fifo_data_v
//  fifo_data_v    in   1           FIFO read-data valid, 1 clk after rd_en
//  fifo_empty     in   1           FIFO empty; registered, lags by 1 clk
//  out_valid      out  1           downstream data valid
//  out_data       out  DATA_WIDTH  downstream data (head of skid buffer)
//  out_ready      in   1           downstream accept
//  busy           out  1           state != IDLE or buffer non-empty
//  flush_done     out  1           1-clk pulse when flush completes
//  beat_count     out  CNT_WIDTH   delivered beats; wraps
//  null_rd_count  out  CNT_WIDTH   reads that returned no data; saturates
//  err            out  1           sticky protocol error
//
// BEHAVIOUR
//  Reset:
//  - state=IDLE, buffer empty, inflight=0.
//  - All outputs 0: fifo_rd_en, out_valid, out_data, busy, flush_done,
//    beat_count, null_rd_count, err.
//
//  State machine (IDLE, RUN, FLUSH):
//  - IDLE -> RUN when enable=1. RUN -> IDLE when enable=0.
//  - Any state -> FLUSH on flush_req. flush_req has priority over enable.
//  - FLUSH -> IDLE when the exit condition below is met; flush_done is
//    high for that one cycle.
//
//  Definitions:
//  - inflight = fifo_rd_en registered (exactly 1-clk read latency).
//  - pop = out_valid & out_ready.
//  - occ = number of skid buffer entries.
//
//  Read issue in RUN:
//  - fifo_rd_en = enable & ~fifo_empty & (occ + inflight - pop < BUF_DEPTH).
//    This is combinational and never over-commits the buffer.
//  - With BUF_DEPTH=2 and out_ready held high, throughput is 1 beat/clk.
//
//  Read issue in IDLE:
//  - fifo_rd_en = 0.
//  - The buffer still drains to the output; in-flight data is still
//    captured.
//
//  Skid buffer:
//  - Circular, wr/rd pointers wrap at BUF_DEPTH.
//  - fifo_data_v writes fifo_data at the tail.
//  - pop advances the head.
//  - A write and a pop in the same cycle are both legal; occ is unchanged.
//
//  Output handshake:
//  - out_valid = (occ != 0) and state != FLUSH.
//  - out_data is the head entry. out_data is stable while
//    out_valid & ~out_ready.
//
//  Error and counter rules:
//  - inflight & ~fifo_data_v: null read (FIFO empty flag lagged).
//    null_rd_count += 1, saturating at all-ones.
//  - fifo_data_v & ~inflight: err <= 1; the data is dropped.
//  - fifo_data_v with occ==BUF_DEPTH and no pop: err <= 1; the data is
//    dropped.
//  - err is sticky; only rst clears it.
//  - beat_count += 1 on each pop, wrapping modulo 2^CNT_WIDTH.
//    Flushed beats are not counted.
//
//  FLUSH:
//  - On the entry cycle the buffer is cleared (occ=0) and out_valid is
//    forced to 0.
//  - fifo_rd_en = ~fifo_empty every cycle, ignoring enable and buffer
//    space.
//  - Returned data is discarded and is not counted in beat_count.
//  - Exit when fifo_empty=1 and inflight=0 for 2 consecutive cycles. This
//    covers the empty-flag lag.
//  - flush_req asserted while in FLUSH is ignored.
//  - After exit the state is IDLE, even if enable=1; RUN resumes on the
//    next cycle.
//
//  Reset mid-operation:
//  - Buffer, inflight and counters are cleared in the reset cycle.
//  - The FIFO shares rst, so no fifo_data_v follows reset release.
//
// TESTING
//  1. Reset with FIFO holding 3 words, enable=0
//     -> all outputs 0, fifo_rd_en stays 0.
//  2. FIFO preloaded with 8 words A0..A7, enable=1, out_ready=1
//     -> out_valid from cycle 3, one beat/clk in order, beat_count=8,
//        err=0.
//  3. 8 words, out_ready toggling 1,0,0,1
//     -> no loss or duplication, out_data stable while stalled,
//        occ never exceeds 2, err=0.
//  4. FIFO holds 1 word; fifo_empty stays 0 one extra cycle, forcing a
//     second rd_en -> exactly 1 beat delivered, null_rd_count=1, err=0.
//  5. 5 words buffered/in FIFO, flush_req pulse
//     -> out_valid drops next cycle, FIFO drained, flush_done single
//        pulse, state IDLE, beat_count unchanged.
//  6. fifo_data_v=1 with no prior fifo_rd_en
//     -> err=1 and stays 1 until rst; buffer unchanged.

Source files
------------

// File: rtl/ase_fifo_drain.sv
`timescale 1ns/1ps
// ase_fifo_drain
//   Read-side engine for a sync FIFO with a registered empty flag and a
//   1-cycle read latency. Issues read strobes, absorbs the latency in a small
//   circular skid buffer and presents the data as a valid/ready stream.
//   A flush discards buffered data and drains the FIFO before returning idle.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   enable         1 = fetch from FIFO, 0 = stop issuing reads
//   flush_req      pulse: discard buffer and drain FIFO
//   fifo_rd_en     read strobe to FIFO (combinational)
//   fifo_data/_v   FIFO read data and its valid, one clock after fifo_rd_en
//   fifo_empty     FIFO empty flag (registered, may lag by one clock)
//   out_valid/out_data/out_ready  downstream stream
//   busy           engine active or buffer holding data
//   flush_done     one-clock pulse when a flush finishes
//   beat_count     delivered beats (wraps)
//   null_rd_count  reads that returned nothing (saturates)
//   err            sticky protocol error
module ase_fifo_drain #(
  parameter int DATA_WIDTH = 64,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush_req,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_data_v,
  input  logic                  fifo_empty,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  flush_done,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  null_rd_count,
  output logic                  err
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  // One extra bit so occupancy plus the in-flight read never overflows.
  localparam int OCC_W = $clog2(BUF_DEPTH + 1) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [DATA_WIDTH-1:0] mem_r [BUF_DEPTH];
  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [OCC_W-1:0]      occ_r;
  logic                  inflight_r;
  logic                  empty_seen_r;
  logic                  flush_done_r;
  logic                  err_r;
  logic [CNT_WIDTH-1:0]  beat_cnt_r;
  logic [CNT_WIDTH-1:0]  null_cnt_r;

  logic                  pop_s;
  logic                  full_s;
  logic                  wr_s;
  logic                  err_set_s;
  logic                  flush_go_s;
  logic                  flush_cond_s;
  logic                  flush_exit_s;
  logic                  rd_en_s;
  logic [OCC_W-1:0]      commit_s;
  logic [OCC_W-1:0]      limit_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUF_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Handshake, buffer-write qualification, flush exit and error detection.
  always_comb begin
    out_valid    = (occ_r != {OCC_W{1'b0}}) && (state_r != ST_FLUSH);
    pop_s        = out_valid & out_ready;
    full_s       = (occ_r == OCC_W'(BUF_DEPTH));
    flush_go_s   = flush_req & (state_r != ST_FLUSH);
    // Comparing occ+inflight against depth+pop avoids an underflowing subtract.
    commit_s     = occ_r + {{(OCC_W-1){1'b0}}, inflight_r};
    limit_s      = OCC_W'(BUF_DEPTH) + {{(OCC_W-1){1'b0}}, pop_s};
    wr_s         = fifo_data_v & inflight_r & (state_r != ST_FLUSH) &
                   ~flush_go_s & (~full_s | pop_s);
    err_set_s    = fifo_data_v & (~inflight_r | (full_s & ~pop_s));
    flush_cond_s = fifo_empty & ~inflight_r;
    // Two consecutive quiet cycles cover the lag of the registered empty flag.
    flush_exit_s = (state_r == ST_FLUSH) & flush_cond_s & empty_seen_r;
  end

  // Next-state and read-strobe decode.
  always_comb begin
    state_nxt_s = state_r;
    rd_en_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (flush_req) begin
          state_nxt_s = ST_FLUSH;
        end else if (enable) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        rd_en_s = enable & ~fifo_empty & (commit_s < limit_s);
        if (flush_req) begin
          state_nxt_s = ST_FLUSH;
        end else if (!enable) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        rd_en_s = ~fifo_empty;
        if (flush_exit_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        rd_en_s     = 1'b0;
      end
    endcase
  end

  // State register, read-latency tracking and flush bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      inflight_r   <= 1'b0;
      empty_seen_r <= 1'b0;
      flush_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      inflight_r   <= rd_en_s;
      empty_seen_r <= (state_r == ST_FLUSH) & flush_cond_s;
      flush_done_r <= flush_exit_s;
    end
  end

  // Skid buffer pointers and occupancy; flush entry empties the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= {PTR_W{1'b0}};
      tail_r <= {PTR_W{1'b0}};
      occ_r  <= {OCC_W{1'b0}};
    end else if (flush_go_s) begin
      head_r <= {PTR_W{1'b0}};
      tail_r <= {PTR_W{1'b0}};
      occ_r  <= {OCC_W{1'b0}};
    end else begin
      if (wr_s) begin
        tail_r <= ptr_inc(tail_r);
      end
      if (pop_s) begin
        head_r <= ptr_inc(head_r);
      end
      occ_r <= occ_r + {{(OCC_W-1){1'b0}}, wr_s} - {{(OCC_W-1){1'b0}}, pop_s};
    end
  end

  // Skid buffer storage; payload needs no reset since out_data is gated.
  always_ff @(posedge clk) begin
    if (wr_s && !rst) begin
      mem_r[tail_r] <= fifo_data;
    end
  end

  // Beat and null-read counters plus the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_r <= {CNT_WIDTH{1'b0}};
      null_cnt_r <= {CNT_WIDTH{1'b0}};
      err_r      <= 1'b0;
    end else begin
      if (pop_s) begin
        beat_cnt_r <= beat_cnt_r + CNT_WIDTH'(1);
      end
      if (inflight_r && !fifo_data_v && (null_cnt_r != {CNT_WIDTH{1'b1}})) begin
        null_cnt_r <= null_cnt_r + CNT_WIDTH'(1);
      end
      if (err_set_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign fifo_rd_en    = rd_en_s;
  assign out_data      = out_valid ? mem_r[head_r] : {DATA_WIDTH{1'b0}};
  assign busy          = (state_r != ST_IDLE) || (occ_r != {OCC_W{1'b0}});
  assign flush_done    = flush_done_r;
  assign beat_count    = beat_cnt_r;
  assign null_rd_count = null_cnt_r;
  assign err           = err_r;

endmodule
